// File: rtl/joy_event_encoder.sv
// Joystick event encoder: resynchronises and debounces twelve active-low button lines,
// presents them as an active-high level bus and streams one press/release byte per change.
module joy_event_encoder #(
   parameter int CLK_DIV      = 1024,
   parameter int STABLE_TICKS = 4
) (
   input  logic        clk,
   input  logic        clock_locked,
   input  logic [5:0]  joy1_n,
   input  logic [5:0]  joy2_n,
   output logic [11:0] joy_state,
   output logic        ev_valid,
   output logic [7:0]  ev_data,
   input  logic        ev_ready
);

   localparam int            TW          = $clog2(CLK_DIV);
   localparam logic [TW-1:0] TICK_LAST   = TW'(CLK_DIV - 1);
   localparam logic [2:0]    STABLE_LAST = 3'(STABLE_TICKS);
   localparam logic [3:0]    LAST_IDX    = 4'd11;

   typedef enum logic {SCAN, OFFER} state_t;

   logic [11:0]   meta_q;
   logic [11:0]   sync_q;
   logic [TW-1:0] tick_cnt_q;
   logic          tick;
   logic [11:0]   deb_q;
   logic [11:0]   deb_d;
   logic [2:0]    cnt_q [12];
   logic [2:0]    cnt_d [12];
   logic [11:0]   joy_state_q;
   logic [11:0]   rep_q;
   logic [3:0]    idx_q;
   logic [3:0]    lat_idx_q;
   logic          snap_q;
   state_t        state_q;
   logic          ev_valid_q;
   logic [7:0]    ev_data_q;

   function automatic logic [3:0] next_idx(input logic [3:0] i);
      return (i == LAST_IDX) ? 4'd0 : i + 4'd1;
   endfunction

   function automatic logic [7:0] event_byte(input logic [3:0] i, input logic released);
      logic       is_p2;
      logic [2:0] bit_i;
      is_p2 = (i >= 4'd6);
      bit_i = is_p2 ? 3'(i - 4'd6) : i[2:0];
      return {released, is_p2, 3'b000, bit_i};
   endfunction

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge clock_locked) begin
      if (!clock_locked) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= {joy2_n, joy1_n};
         sync_q <= meta_q;
      end
   end

   assign tick = (tick_cnt_q == TICK_LAST);

   always_ff @(posedge clk or negedge clock_locked) begin
      if (!clock_locked) tick_cnt_q <= '0;
      else               tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 12; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] + 3'd1 == STABLE_LAST) begin
               deb_d[i] = sync_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 3'd1;
            end
         end
      end
   end

   // NOTE: the per-bit counters are plain flops, not a RAM, so resetting them is cheap and safe.
   always_ff @(posedge clk or negedge clock_locked) begin
      if (!clock_locked) begin
         deb_q       <= '1;
         joy_state_q <= '0;
         for (int i = 0; i < 12; i++) cnt_q[i] <= '0;
      end else begin
         deb_q       <= deb_d;
         joy_state_q <= ~deb_q;
         for (int i = 0; i < 12; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // rep_q holds what the consumer has been told; it only moves on a completed handshake.
   always_ff @(posedge clk or negedge clock_locked) begin
      if (!clock_locked) begin
         state_q    <= SCAN;
         idx_q      <= '0;
         lat_idx_q  <= '0;
         snap_q     <= 1'b1;
         rep_q      <= '1;
         ev_valid_q <= 1'b0;
         ev_data_q  <= '0;
      end else begin
         case (state_q)
            SCAN: begin
               if (deb_q[idx_q] != rep_q[idx_q]) begin
                  ev_data_q  <= event_byte(idx_q, deb_q[idx_q]);
                  snap_q     <= deb_q[idx_q];
                  lat_idx_q  <= idx_q;
                  ev_valid_q <= 1'b1;
                  state_q    <= OFFER;
               end else begin
                  idx_q <= next_idx(idx_q);
               end
            end
            OFFER: begin
               if (ev_ready) begin
                  rep_q[lat_idx_q] <= snap_q;
                  ev_valid_q       <= 1'b0;
                  idx_q            <= next_idx(lat_idx_q);
                  state_q          <= SCAN;
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign joy_state = joy_state_q;
   assign ev_valid  = ev_valid_q;
   assign ev_data   = ev_data_q;

endmodule

// File: tb/tb_joy_event_encoder.sv
// Scoreboard bench for joy_event_encoder: stimulus pushes expected event bytes, a negedge
// monitor pops them on each handshake and checks hold-stability under backpressure.
module tb_joy_event_encoder;

   localparam int CLK_DIV      = 4;
   localparam int STABLE_TICKS = 3;

   logic        clk          = 1'b0;
   logic        clock_locked = 1'b0;
   logic [5:0]  joy1_n       = '1;
   logic [5:0]  joy2_n       = '1;
   logic [11:0] joy_state;
   logic        ev_valid;
   logic [7:0]  ev_data;
   logic        ev_ready     = 1'b0;

   joy_event_encoder #(.CLK_DIV(CLK_DIV), .STABLE_TICKS(STABLE_TICKS)) dut (
      .clk          (clk),
      .clock_locked (clock_locked),
      .joy1_n       (joy1_n),
      .joy2_n       (joy2_n),
      .joy_state    (joy_state),
      .ev_valid     (ev_valid),
      .ev_data      (ev_data),
      .ev_ready     (ev_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         grp;
   } exp_t;

   exp_t        exp_q[$];
   int          seq_q[$];
   int          checks       = 0;
   int          errors       = 0;
   int          grp_cnt      = 0;
   logic [11:0] cur_in       = '1;
   bit          rnd_ready_en = 1'b0;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Event byte derived directly from the byte layout: release flag, player, bit within player.
   function automatic logic [7:0] ev_byte(input int idx, input logic released);
      logic [7:0] b;
      b      = '0;
      b[7]   = released;
      b[6]   = (idx >= 6);
      b[2:0] = 3'(idx % 6);
      return b;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [11:0] v);
      cur_in = v;
      joy1_n = v[5:0];
      joy2_n = v[11:6];
   endtask

   // A settled change of several bits at once is one group; bytes within it may arrive in
   // any rotation of ascending index order.
   task automatic change(input logic [11:0] v);
      grp_cnt++;
      for (int i = 0; i < 12; i++)
         if (v[i] != cur_in[i]) exp_q.push_back('{ev_byte(i, v[i]), grp_cnt});
      drive(v);
   endtask

   task automatic consume(input logic [7:0] d);
      int found;
      int g;
      int desc;
      if (exp_q.size() == 0) begin
         check(1'b0, "unexpected_event", 32'(d), 32'hFFFF_FFFF);
         return;
      end
      g     = exp_q[0].grp;
      found = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].grp == g && exp_q[i].data == d) begin
            found = i;
            break;
         end
      end
      check(found >= 0, "event_byte", 32'(d), 32'(exp_q[0].data));
      if (found < 0) return;
      exp_q.delete(found);
      seq_q.push_back((d[6] ? 6 : 0) + int'(d[2:0]));
      if (exp_q.size() == 0 || exp_q[0].grp != g) begin
         if (seq_q.size() >= 3) begin
            desc = 0;
            for (int i = 0; i < seq_q.size(); i++)
               if (seq_q[(i + 1) % seq_q.size()] < seq_q[i]) desc++;
            check(desc == 1, "group_order", 32'(desc), 32'd1);
         end
         seq_q.delete();
      end
   endtask

   initial begin : monitor
      bit         pending;
      logic [7:0] prev_data;
      pending   = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (!clock_locked) begin
            pending = 1'b0;
         end else begin
            if (pending)
               check(ev_valid === 1'b1 && ev_data === prev_data, "hold_stable",
                     {23'b0, ev_valid, ev_data}, {23'b0, 1'b1, prev_data});
            if (ev_valid === 1'b1 && ev_ready) consume(ev_data);
            pending   = (ev_valid === 1'b1) && !ev_ready;
            prev_data = ev_data;
         end
      end
   end

   initial begin : ready_driver
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready_en) ev_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic settle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ev_valid) && n < 600) begin
         cyc(1);
         n++;
      end
      check(n < 600, {name, "_drain"}, 32'(exp_q.size()), 32'd0);
      cyc(30);
      check(joy_state === ~cur_in, {name, "_state"}, 32'(joy_state), 32'(~cur_in));
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (ev_valid !== 1'b1 && n < 200) begin
         cyc(1);
         n++;
      end
      check(ev_valid === 1'b1, name, 32'(ev_valid), 32'd1);
   endtask

   initial begin : stimulus
      logic [11:0] m;
      int          b;
      int          len;

      drive('1);
      cyc(3);
      check(joy_state === 12'h000, "rst_joy_state", 32'(joy_state), 32'h0);
      check(ev_valid === 1'b0, "rst_ev_valid", 32'(ev_valid), 32'h0);
      check(ev_data === 8'h00, "rst_ev_data", 32'(ev_data), 32'h0);
      clock_locked = 1'b1;
      for (int i = 0; i < 200; i++) begin
         cyc(1);
         check(joy_state === 12'h000 && ev_valid === 1'b0, "idle_after_reset",
               {19'b0, joy_state, ev_valid}, 32'h0);
      end

      // Single press and release of joy1 fire1.
      ev_ready = 1'b1;
      change(cur_in & ~12'h002);
      settle("press_fire1");
      change(cur_in | 12'h002);
      settle("release_fire1");

      // Bounce on joy2 up shorter than the debounce window, ending released.
      for (int k = 0; k < 20; k++) begin
         drive(cur_in ^ 12'h800);
         cyc(5);
      end
      drive(cur_in | 12'h800);
      settle("bounce");

      change(cur_in & ~12'h800);
      settle("held_up2");
      change(cur_in | 12'h800);
      settle("release_up2");

      // Backpressure with joy1 up+right pressed together.
      ev_ready = 1'b0;
      change(cur_in & ~12'h024);
      cyc(50);
      check(ev_valid === 1'b1, "bp_valid_held", 32'(ev_valid), 32'd1);
      check(ev_data === 8'h02 || ev_data === 8'h05, "bp_first_byte", 32'(ev_data), 32'h02);
      ev_ready = 1'b1;
      settle("bp_press");
      change(cur_in | 12'h024);
      settle("bp_release");

      // Bit released again while its press event is still pending.
      ev_ready = 1'b0;
      change(cur_in & ~12'h001);
      wait_valid("pending_valid");
      change(cur_in | 12'h001);
      cyc(40);
      check(ev_data === 8'h00, "pending_byte", 32'(ev_data), 32'h00);
      ev_ready = 1'b1;
      settle("pending");

      // Random glitches and settled multi-bit changes under random backpressure.
      rnd_ready_en = 1'b1;
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 2) == 0) begin
            b   = $urandom_range(0, 11);
            len = $urandom_range(1, 8);
            drive(cur_in ^ (12'h001 << b));
            cyc(len);
            drive(cur_in ^ (12'h001 << b));
         end else begin
            m = '0;
            repeat ($urandom_range(1, 3)) m[$urandom_range(0, 11)] = 1'b1;
            change(cur_in ^ m);
         end
         settle("random");
      end
      rnd_ready_en = 1'b0;
      cyc(2);
      ev_ready = 1'b1;
      change('1);
      settle("random_idle");

      // Asynchronous reset while an event is offered.
      ev_ready = 1'b0;
      change(cur_in & ~12'h008);
      wait_valid("prereset_valid");
      check(ev_data === 8'h03, "prereset_byte", 32'(ev_data), 32'h03);
      @(negedge clk);
      #2;
      clock_locked = 1'b0;
      #1;
      check(ev_valid === 1'b0, "async_drop", 32'(ev_valid), 32'd0);
      exp_q.delete();
      seq_q.delete();
      drive('1);
      cyc(3);
      clock_locked = 1'b1;
      ev_ready     = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         check(joy_state === 12'h000 && ev_valid === 1'b0, "post_reset_idle",
               {19'b0, joy_state, ev_valid}, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/joy_event_encoder.md
Name: joy_event_encoder

Overview:
- Downstream consumer of the serial joystick decoder's twelve active-low button/direction outputs, two players × six signals.
- Resynchronises them into the system clock domain, debounces each bit, and presents the stable state as an active-high level bus.
- Emits one press/release event byte per state change on a valid/ready stream for the core/OSD input logic.
- No transition of the final settled state is ever lost, even under backpressure.

Parameters:
- CLK_DIV, 1024: system clocks per debounce sample tick (≥2).
- STABLE_TICKS, 4: consecutive ticks a synchronised bit must differ from its debounced value before being accepted (1..7).

Ports:
- clk  in  1  system clock.
- clock_locked  in  1  reset, asynchronous, active-low.
- joy1_n  in  6  player 1, active-low, async to clk. Bit map: [5] up, [4] down, [3] left, [2] right, [1] fire1, [0] fire2.
- joy2_n  in  6  player 2, active-low, same bit map.
- joy_state  out  12  debounced level, active-high. [11:6] = player 2, [5:0] = player 1, same bit map.
- ev_valid  out  1  event byte available.
- ev_data  out  8  event byte.
  - [7] 1 = release, 0 = press.
  - [6] player: 0 = joy1, 1 = joy2.
  - [5:3] 000.
  - [2:0] bit index 0..5.
- ev_ready  in  1  consumer accepts ev_data when ev_valid && ev_ready at posedge clk.

Behaviour:
- Reset (clock_locked low, async):
  - joy_state = 0.
  - Internal debounced and reported vectors = 12'hFFF (released).
  - ev_valid = 0, ev_data = 0.
  - Synchroniser flops = 1.
  - Tick counter, per-bit counters and scan index = 0.
  - FSM = SCAN.
- Synchroniser: 2-flop per bit, giving sync[11:0] = {joy2_n, joy1_n}.
- Tick: counter 0..CLK_DIV-1 wrapping; tick is asserted for one clk when the counter equals CLK_DIV-1.
- Debounce, per bit i, 3-bit counter:
  - If sync[i] == deb[i], clear the counter immediately, every clk.
  - Otherwise increment on each tick.
  - On the tick where the counter reaches STABLE_TICKS, deb[i] <= sync[i] and the counter clears.
  - joy_state = ~deb, registered, so it lags deb by one clk.
- Event FSM, two states:
  - SCAN: each clk examine index idx (0..11). If deb[idx] != rep[idx], then:
    - ev_data <= {deb[idx], idx≥6, 3'b000, idx mod 6}.
    - Latch the snapshot value and idx.
    - ev_valid <= 1, go to OFFER.
    - Otherwise idx <= idx+1, wrapping 11→0.
  - OFFER: hold ev_data and ev_valid stable while ev_ready = 0. On the handshake:
    - rep[latched idx] <= snapshot value.
    - ev_valid <= 0.
    - idx <= latched idx + 1 (wrap).
    - Return to SCAN.
  - At most one event per two clks; the scan is round-robin, so all twelve bits are served fairly.
- Bit toggling while its event is pending: the pending byte is delivered unchanged, and rep takes the snapshot value. The next scan sees the mismatch and emits a fresh event. Press/release always alternate per bit.
- Multiple bits changing on the same tick: events are emitted in ascending idx order starting from the current scan position.
- ev_ready high with ev_valid low: ignored.
- Latency, input edge to ev_valid with ev_ready held high: 2 (sync) + up to STABLE_TICKS·CLK_DIV (debounce) + ≤12 (scan) + 1 clk.
- Reset mid-OFFER: the event is dropped, ev_valid falls asynchronously, and everything returns to reset values.
- ev_data bits [5:3] are always 0.

Test Plan (bench with CLK_DIV=4, STABLE_TICKS=3):
- Reset: hold inputs 12'hFFF, release reset → joy_state=0, ev_valid=0 for 200 clks.
- Single press: joy1_n[1]=0 (fire1), ev_ready=1 → one byte 8'h01, then joy_state=12'h002. Releasing the bit → one byte 8'h81, joy_state=0.
- Bounce rejection: toggle joy2_n[5] every 5 clks for 100 clks, then release → no events, joy_state unchanged.
- Held pressed: hold joy2_n[5] low → exactly one byte 8'h45.
- Backpressure: press joy1 up+right together (joy1_n=6'b011011) with ev_ready=0 for 50 clks:
  - First byte 8'h02, stable while ready is low.
  - After ready rises: 8'h02 then 8'h05, in order; no extra bytes.
- Change while pending:
  - Press joy1 fire2 with ev_ready=0.
  - Release it before asserting ready.
  - Result: exactly 8'h00 then 8'h80.
- Async reset while ev_valid=1 → ev_valid drops immediately. After reset release with inputs idle, no stale event appears.
